// File: rtl/noise_mixer_if.sv
`default_nettype none
// ============================================================================
//  Module   : noise_mixer_if
//  Brief    : Sample-stream bundle between the signal source / noise
//             generator side (master) and the noise mixer (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface noise_mixer_if #(
    parameter int NOISE_BITS = 4,
    parameter int SIG_BITS   = 4,
    parameter int OUT_BITS   = 6
);
    logic                  ena_in;
    logic [SIG_BITS-1:0]   signal_in;
    logic [NOISE_BITS-1:0] noise_in;
    logic                  noise_start_in;
    logic [1:0]            noise_shift_in;
    logic                  noise_ena_out;
    logic [OUT_BITS-1:0]   sample_out;
    logic                  valid_out;
    logic                  sat_out;
    logic                  frame_out;

    modport master (
        output ena_in, signal_in, noise_in, noise_start_in, noise_shift_in,
        input  noise_ena_out, sample_out, valid_out, sat_out, frame_out
    );

    modport slave (
        input  ena_in, signal_in, noise_in, noise_start_in, noise_shift_in,
        output noise_ena_out, sample_out, valid_out, sat_out, frame_out
    );
endinterface
`default_nettype wire

// File: rtl/noise_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : noise_mixer
//  Brief    : Sliding-window average of LFSR noise (approx. Gaussian),
//             scaled by a run-time arithmetic shift, added to the signal
//             sample and saturated. Two register stages.
//  Revision : 1.0  initial release
// ============================================================================
module noise_mixer #(
    parameter int NOISE_BITS = 4,
    parameter int SIG_BITS   = 4,
    parameter int SUM_LOG2   = 2,
    parameter int OUT_BITS   = 6
) (
    input  logic          clk_in,
    input  logic          rst_in,
    noise_mixer_if.slave  bus
);
    localparam int C_WIN   = 1 << SUM_LOG2;
    localparam int C_SUM_W = NOISE_BITS + SUM_LOG2;
    localparam int C_CNT_W = SUM_LOG2 + 1;
    localparam int C_TOT_W = ((C_SUM_W > SIG_BITS) ? C_SUM_W : SIG_BITS) + 1;
    // One extra bit beyond both the sum width and the output range so the
    // clamp bounds are always representable and compare correctly.
    localparam int C_EXT_W = ((C_TOT_W > OUT_BITS) ? C_TOT_W : OUT_BITS) + 1;

    localparam logic [C_CNT_W-1:0] C_FILL_FULL = C_CNT_W'(C_WIN);
    localparam logic [C_CNT_W-1:0] C_FILL_LAST = C_CNT_W'(C_WIN - 1);
    localparam logic signed [C_EXT_W-1:0] C_SAT_MAX =
        C_EXT_W'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1);
    localparam logic signed [C_EXT_W-1:0] C_SAT_MIN =
        C_EXT_W'(-(64'sd1 <<< (OUT_BITS - 1)));

    // Stage A state: window (entry 0 newest), running sum, fill counter
    logic signed [NOISE_BITS-1:0] win_q [C_WIN];
    logic signed [C_SUM_W-1:0]    sum_q;
    logic signed [C_SUM_W-1:0]    sum_d;
    logic [C_CNT_W-1:0]           fill_q;
    logic [C_CNT_W-1:0]           fill_d;
    logic                         va_q;
    logic signed [SIG_BITS-1:0]   siga_q;
    logic                         frma_q;

    // Stage B state: registered outputs
    logic signed [OUT_BITS-1:0]   sample_q;
    logic                         valid_q;
    logic                         sat_q;
    logic                         frame_q;

    logic signed [NOISE_BITS-1:0] w_noise;
    logic signed [C_SUM_W-1:0]    w_scaled;
    logic signed [C_EXT_W-1:0]    w_total;
    logic signed [C_EXT_W-1:0]    w_clamped;
    logic                         w_clip;

    assign w_noise = $signed(bus.noise_in);

    // Next running sum and saturating fill count for an enabled sample
    always_comb begin
        sum_d  = sum_q + C_SUM_W'(w_noise) - C_SUM_W'(win_q[C_WIN-1]);
        fill_d = (fill_q == C_FILL_FULL) ? fill_q : fill_q + C_CNT_W'(1);
    end

    // Scale the window sum, add the signal and clamp to the output range
    always_comb begin
        w_scaled  = sum_q >>> bus.noise_shift_in;
        w_total   = C_EXT_W'(w_scaled) + C_EXT_W'(siga_q);
        w_clamped = w_total;
        w_clip    = 1'b0;
        if (w_total > C_SAT_MAX) begin
            w_clamped = C_SAT_MAX;
            w_clip    = 1'b1;
        end else if (w_total < C_SAT_MIN) begin
            w_clamped = C_SAT_MIN;
            w_clip    = 1'b1;
        end
    end

    // Stage A: window shift, sum update and capture of the sample context
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < C_WIN; i++) begin
                win_q[i] <= '0;
            end
            sum_q  <= '0;
            fill_q <= '0;
            va_q   <= 1'b0;
            siga_q <= '0;
            frma_q <= 1'b0;
        end else begin
            // Valid once this update completes a window of real samples
            va_q <= bus.ena_in & ((fill_q == C_FILL_LAST) | (fill_q == C_FILL_FULL));
            if (bus.ena_in) begin
                win_q[0] <= w_noise;
                for (int i = 1; i < C_WIN; i++) begin
                    win_q[i] <= win_q[i-1];
                end
                sum_q  <= sum_d;
                fill_q <= fill_d;
                siga_q <= $signed(bus.signal_in);
                frma_q <= bus.noise_start_in;
            end
        end
    end

    // Stage B: register the mixed sample; sample/sat hold while not valid
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            valid_q <= va_q;
            if (va_q) begin
                sample_q <= OUT_BITS'(w_clamped);
                sat_q    <= w_clip;
                frame_q  <= frma_q;
            end else begin
                frame_q  <= 1'b0;
            end
        end
    end

    assign bus.noise_ena_out = bus.ena_in;
    assign bus.sample_out    = sample_q;
    assign bus.valid_out     = valid_q;
    assign bus.sat_out       = sat_q;
    assign bus.frame_out     = frame_q;

endmodule
`default_nettype wire

// File: doc/noise_mixer.md
# noise_mixer

Downstream consumer of the LFSR noise generator in the GPS signal-generator datapath. Each enabled cycle it takes one uniform signed noise word and averages it over a sliding window of 2^SUM_LOG2 samples, which gives an approximately Gaussian noise sample. It scales that sample by a run-time arithmetic shift, adds it to the modulated signal sample, and saturates the result. It also drives the generator's enable input and re-times the generator's period-start pulse so that it lines up with the output sample.

## Interface

Parameters:
- NOISE_BITS, 4: width of the signed noise word from the generator.
- SIG_BITS, 4: width of the signed signal sample.
- SUM_LOG2, 2: log2 of the window length. Window length W = 2^SUM_LOG2.
- OUT_BITS, 6: width of the signed, saturated output.

Ports:
- clk_in, input, 1: the only clock; all logic uses the rising edge.
- rst_in, input, 1: asynchronous, active-high reset.
- ena_in, input, 1: a sample is consumed on each rising edge where ena_in is high.
- signal_in, input, SIG_BITS: signed signal sample.
- noise_in, input, NOISE_BITS: signed noise word, connected to the generator's noise output.
- noise_start_in, input, 1: the generator's period-start pulse.
- noise_shift_in, input, 2: right-shift amount (0..3) applied to the window sum.
- noise_ena_out, output, 1: enable to the generator; equals ena_in combinationally.
- sample_out, output, OUT_BITS: signed, saturated signal + noise.
- valid_out, output, 1: sample_out is valid for this cycle.
- sat_out, output, 1: sample_out was clipped; qualified by valid_out.
- frame_out, output, 1: sample_out contains the noise word taken at a period start; qualified by valid_out.

## Operation

**Stage A** (registers update on an edge with ena_in = 1):
- The window shift register (W entries × NOISE_BITS) shifts noise_in in.
- The running sum is updated as sum <= sum + noise_in - oldest.
  - The sum is signed, SUM_W = NOISE_BITS + SUM_LOG2 bits wide, and never overflows.
  - "oldest" is the entry leaving the window.
- fill_cnt increments and saturates at W.
- Every edge, independent of ena_in:
  - vA <= ena_in & (fill_cnt == W-1 or fill_cnt == W), i.e. the window holds W real samples after this update.
  - sigA <= signal_in and frmA <= noise_start_in, captured only when ena_in = 1.

**Stage B** (every edge):
- valid_out <= vA.
- When vA = 1, using the current noise_shift_in:
  - scaled = sum >>> noise_shift_in (arithmetic shift; rounds toward minus infinity).
  - total = scaled + sign-extended sigA, computed at max(SUM_W, SIG_BITS) + 1 bits.
  - sample_out = total clamped to [-2^(OUT_BITS-1), 2^(OUT_BITS-1) - 1].
  - sat_out = 1 if clamping occurred, else 0.
  - frame_out <= frmA.
- When vA = 0: sample_out and sat_out hold their values; frame_out <= 0.

**Other rules:**
- ena_in low stalls the stream. The window and sum are frozen, and no output is produced for that sample.
- Reset clears the shift register, sum, fill_cnt, all pipeline registers and all outputs.
  - A reset in the middle of a stream discards any partial window.
  - After reset, W new samples are needed before valid_out rises again.
- noise_shift_in can change at any time. It takes effect on the first stage-B edge after the change.

## Timing

- Reset values: sample_out = 0, valid_out = 0, sat_out = 0, frame_out = 0.
  - noise_ena_out follows ena_in during reset.
- Latency: a sample consumed at edge E0 appears on sample_out and valid_out after edge E1. This is 2 register stages: the outputs are valid in the cycle after E1.
- Warm-up: the first valid output corresponds to the W-th consumed sample after reset.
- Throughput: one output per enabled cycle; no back-pressure.
- Simultaneous events:
  - rst_in wins over ena_in.
  - noise_start_in is captured only when ena_in = 1.

## Test plan

1. **Reset.** Assert rst_in asynchronously mid-cycle while ena_in = 1 and outputs are non-zero. Required: all outputs go to 0 immediately. After release, with W = 4, valid_out stays 0 for the first 3 samples.
2. **Warm-up and latency.** Hold noise_in = 1, signal_in = 0, shift = 0, ena_in = 1, and consume samples s1..s4 at edges E1..E4. Required: valid_out first rises after E5 with sample_out = 4 and sat_out = 0.
3. **Saturation.**
   - Window all 7, signal_in = 7, shift = 0: required sample_out = 31, sat_out = 1.
   - Window all -8, signal_in = -8: required sample_out = -32, sat_out = 1.
4. **Shift rounding.** Window (-5, -5, -5, -6): sum = -21.
   - shift = 2, signal_in = 3: required sample_out = -3 (-21 >>> 2 = -6, plus 3), sat_out = 0.
   - shift = 0: required sample_out = -18.
5. **Stall.** With the window full, drop ena_in for 3 cycles, then resume with the next noise word. Required: valid_out is low for exactly 3 output cycles, and the next sum equals the pre-stall window shifted by exactly one new sample.
6. **Frame alignment and reset recovery.**
   - Pulse noise_start_in together with the 6th sample. Required: frame_out = 1 on exactly the one valid output for that sample.
   - Reset after sample 7. Required: valid_out = 0 until 4 new samples have been consumed.
